// File: rtl/pipelined_alu_pkg.sv
// Shared types for the two-stage ALU: opcode encoding, flag bundle, opcode width floor.
package pipelined_alu_pkg;

  localparam int ALU_OP_W_MIN = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_NOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_NAND = 4'd4,
    OP_AND  = 4'd5,
    OP_XNOR = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_SLT  = 4'd11,
    OP_SLTU = 4'd12,
    OP_MUL  = 4'd13
  } alu_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_alu_if.sv
// Operand/result handshake bundle; master drives operands and out_ready, slave is the ALU.
interface pipelined_alu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic [OP_WIDTH-1:0]   in_op;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_x;
  logic                  out_z;
  logic                  out_n;
  logic                  out_c;
  logic                  out_v;
  logic                  out_err;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_x, out_z, out_n, out_c, out_v, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_x, out_z, out_n, out_c, out_v, out_err
  );
endinterface

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH cycles, low half kept.
module alu_shift_add_mul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] p
);
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mul_state_e;

  mul_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] acc_q, mcand_q, mplier_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= M_IDLE;
    else         state_q <= state_d;
  end

  // DONE lasts one cycle; the owner latches p then, so a new start is taken straight from DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE, M_DONE: state_d = start ? M_BUSY : M_IDLE;
      M_BUSY:         if (cnt_q == CW'(DATA_WIDTH-1)) state_d = M_DONE;
      default:        state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start && state_q != M_BUSY) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
    end else if (state_q == M_BUSY) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end

  assign busy = (state_q == M_BUSY);
  assign done = (state_q == M_DONE);
  assign p    = acc_q;
endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU with Z/N/C/V/err flags.
// Define PIPELINED_ALU_MUL_EN to add opcode 13 (iterative MUL that stalls S2 while it runs).
module pipelined_alu
  import pipelined_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input logic              clk,
  input logic              resetn,
  pipelined_alu_if.slave   bus
);
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int MSB = DATA_WIDTH - 1;

  logic                  s1_valid_q, s2_valid_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q, x_q, res_d;
  logic [OP_WIDTH-1:0]   s1_op_q;
  alu_flags_t            f_q, f_d;
  alu_op_e               op;
  logic                  legal, c_d, v_d, s1_is_mul;
  logic [SHW-1:0]        sh;
  logic [DATA_WIDTH:0]   sum, dif;
  logic                  out_valid, pop, s1_adv, accept;

  always_comb begin
    op        = alu_op_e'(s1_op_q[3:0]);
    sh        = s1_b_q[SHW-1:0];
    sum       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    dif       = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    legal     = ((s1_op_q >> 4) == '0);
    res_d     = '0;
    c_d       = 1'b0;
    v_d       = 1'b0;
    s1_is_mul = 1'b0;
    case (op)
      OP_ADD: begin
        res_d = sum[MSB:0];
        c_d   = sum[DATA_WIDTH];
        v_d   = (s1_a_q[MSB] == s1_b_q[MSB]) && (sum[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        res_d = dif[MSB:0];
        c_d   = dif[DATA_WIDTH];
        v_d   = (s1_a_q[MSB] != s1_b_q[MSB]) && (dif[MSB] != s1_a_q[MSB]);
      end
      OP_NOR:  res_d = ~(s1_a_q | s1_b_q);
      OP_OR:   res_d = s1_a_q | s1_b_q;
      OP_NAND: res_d = ~(s1_a_q & s1_b_q);
      OP_AND:  res_d = s1_a_q & s1_b_q;
      OP_XNOR: res_d = ~(s1_a_q ^ s1_b_q);
      OP_XOR:  res_d = s1_a_q ^ s1_b_q;
      OP_SLL:  res_d = s1_a_q << sh;
      OP_SRL:  res_d = s1_a_q >> sh;
      OP_SRA:  res_d = $signed(s1_a_q) >>> sh;
      OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
      OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
`ifdef PIPELINED_ALU_MUL_EN
      OP_MUL:  s1_is_mul = legal;
`endif
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      res_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
    end
    f_d = '{z: (res_d == '0), n: res_d[MSB], c: c_d, v: v_d, err: !legal};
  end

  assign pop         = out_valid && bus.out_ready;
  assign s1_adv      = s1_valid_q && (!s2_valid_q || pop);
  assign bus.in_ready = !s1_valid_q || s1_adv;
  assign accept      = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= bus.in_a;
      s1_b_q     <= bus.in_b;
      s1_op_q    <= bus.in_op;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

`ifdef PIPELINED_ALU_MUL_EN
  logic                  mul_wait_q, mul_busy, mul_done;
  logic [DATA_WIDTH-1:0] mul_p;

  alu_shift_add_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk(clk), .resetn(resetn), .start(s1_adv && s1_is_mul),
    .a(s1_a_q), .b(s1_b_q), .busy(mul_busy), .done(mul_done), .p(mul_p)
  );

  // While the MUL beat sits in S2 the product is presented straight from the multiplier in DONE.
  assign out_valid   = s2_valid_q && !mul_busy;
  assign bus.out_x   = mul_wait_q ? mul_p : x_q;
  assign bus.out_z   = mul_wait_q ? (mul_p == '0) : f_q.z;
  assign bus.out_n   = mul_wait_q ? mul_p[MSB] : f_q.n;
  assign bus.out_c   = !mul_wait_q && f_q.c;
  assign bus.out_v   = !mul_wait_q && f_q.v;
  assign bus.out_err = !mul_wait_q && f_q.err;
`else
  assign out_valid   = s2_valid_q;
  assign bus.out_x   = x_q;
  assign bus.out_z   = f_q.z;
  assign bus.out_n   = f_q.n;
  assign bus.out_c   = f_q.c;
  assign bus.out_v   = f_q.v;
  assign bus.out_err = f_q.err;
`endif
  assign bus.out_valid = out_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      f_q        <= '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};
`ifdef PIPELINED_ALU_MUL_EN
      mul_wait_q <= 1'b0;
`endif
    end else if (s1_adv) begin
      s2_valid_q <= 1'b1;
      x_q        <= res_d;
      f_q        <= f_d;
`ifdef PIPELINED_ALU_MUL_EN
      mul_wait_q <= s1_is_mul;
`endif
    end else begin
      if (pop) s2_valid_q <= 1'b0;
`ifdef PIPELINED_ALU_MUL_EN
      if (mul_wait_q && mul_done) begin
        x_q        <= mul_p;
        f_q        <= '{z: (mul_p == '0), n: mul_p[MSB], c: 1'b0, v: 1'b0, err: 1'b0};
        mul_wait_q <= 1'b0;
      end
`endif
    end
  end
endmodule
